// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: turns byte-addressed requests into one or two masked
// word beats and returns a single extended response per request.
module lsu_mem_ctrl #(
  parameter int DW    = 32,
  parameter int ADDRW = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [1:0]       req_size_i,
  input  logic             req_unsigned_i,
  input  logic [ADDRW+1:0] req_addr_i,
  input  logic [DW-1:0]    req_wdata_i,
  output logic             resp_valid_o,
  output logic [DW-1:0]    resp_rdata_o,
  output logic             resp_split_o,
  output logic             mem_cs_o,
  output logic             mem_we_o,
  output logic [3:0]       mem_mask_o,
  output logic [ADDRW-1:0] mem_addr_o,
  output logic [DW-1:0]    mem_wdata_o,
  input  logic [DW-1:0]    mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1,
    RESP
  } state_t;

  state_t      state_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [1:0]  off_q;
  logic [3:0]  en_hi_q;
  logic [31:0] wdata_hi_q;
  logic [31:0] cap0_q;

  logic [3:0]  lane_base;
  logic [7:0]  en8;
  logic [31:0] wdata_masked;
  logic [63:0] wdata_shifted;

  // Lane enables and lane-aligned store data for the incoming request; the
  // upper halves belong to the second beat when the access straddles a word.
  always_comb begin
    lane_base    = 4'b1111;
    wdata_masked = req_wdata_i;
    case (req_size_i)
      2'b00: begin
        lane_base    = 4'b0001;
        wdata_masked = {24'b0, req_wdata_i[7:0]};
      end
      2'b01: begin
        lane_base    = 4'b0011;
        wdata_masked = {16'b0, req_wdata_i[15:0]};
      end
      default: begin
        lane_base    = 4'b1111;
        wdata_masked = req_wdata_i;
      end
    endcase
    en8 = {4'b0000, lane_base} << req_addr_i[1:0];
    case (req_addr_i[1:0])
      2'd0:    wdata_shifted = {32'b0, wdata_masked};
      2'd1:    wdata_shifted = {24'b0, wdata_masked, 8'b0};
      2'd2:    wdata_shifted = {16'b0, wdata_masked, 16'b0};
      default: wdata_shifted = {8'b0, wdata_masked, 24'b0};
    endcase
  end

  // Realign the captured words to the byte offset, then trim and extend.
  // The top byte of the second word can never be part of a 4-byte access.
  function automatic logic [31:0] assemble(input logic [23:0] hi,
                                           input logic [31:0] lo,
                                           input logic [1:0]  off,
                                           input logic [1:0]  size,
                                           input logic        uns);
    logic [31:0] raw;
    case (off)
      2'd0:    raw = lo;
      2'd1:    raw = {hi[7:0], lo[31:8]};
      2'd2:    raw = {hi[15:0], lo[31:16]};
      default: raw = {hi[23:0], lo[31:24]};
    endcase
    case (size)
      2'b00:   assemble = {{24{~uns & raw[7]}}, raw[7:0]};
      2'b01:   assemble = {{16{~uns & raw[15]}}, raw[15:0]};
      default: assemble = raw;
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      off_q        <= 2'b00;
      en_hi_q      <= 4'b0000;
      wdata_hi_q   <= 32'b0;
      cap0_q       <= 32'b0;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      resp_split_o <= 1'b0;
      mem_cs_o     <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_mask_o   <= 4'b0000;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            we_q        <= req_we_i;
            size_q      <= req_size_i;
            unsigned_q  <= req_unsigned_i;
            off_q       <= req_addr_i[1:0];
            en_hi_q     <= en8[7:4];
            wdata_hi_q  <= wdata_shifted[63:32];
            req_ready_o <= 1'b0;
            mem_cs_o    <= 1'b1;
            mem_we_o    <= req_we_i;
            mem_mask_o  <= en8[3:0];
            mem_addr_o  <= req_addr_i[ADDRW+1:2];
            mem_wdata_o <= wdata_shifted[31:0];
            state_q     <= BEAT0;
          end
        end
        BEAT0: begin
          cap0_q <= mem_rdata_i;
          if (en_hi_q != 4'b0000) begin
            mem_addr_o  <= mem_addr_o + ADDRW'(1);
            mem_mask_o  <= en_hi_q;
            mem_wdata_o <= wdata_hi_q;
            state_q     <= BEAT1;
          end else begin
            mem_cs_o     <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_mask_o   <= 4'b0000;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            resp_valid_o <= 1'b1;
            resp_split_o <= 1'b0;
            resp_rdata_o <= we_q ? 32'b0
                                 : assemble(24'b0, mem_rdata_i, off_q, size_q, unsigned_q);
            state_q      <= RESP;
          end
        end
        BEAT1: begin
          mem_cs_o     <= 1'b0;
          mem_we_o     <= 1'b0;
          mem_mask_o   <= 4'b0000;
          mem_addr_o   <= '0;
          mem_wdata_o  <= '0;
          resp_valid_o <= 1'b1;
          resp_split_o <= 1'b1;
          resp_rdata_o <= we_q ? 32'b0
                               : assemble(mem_rdata_i[23:0], cap0_q, off_q, size_q, unsigned_q);
          state_q      <= RESP;
        end
        RESP: begin
          resp_valid_o <= 1'b0;
          resp_split_o <= 1'b0;
          resp_rdata_o <= '0;
          req_ready_o  <= 1'b1;
          state_q      <= IDLE;
        end
        default: begin
          state_q     <= IDLE;
          req_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized self-checking bench for lsu_mem_ctrl against a byte-array model
// of memory and an access-level model of beats, latency and load results.
module tb_lsu_mem_ctrl;

  localparam int ADDRW = 8;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             req_valid_i;
  logic             req_ready_o;
  logic             req_we_i;
  logic [1:0]       req_size_i;
  logic             req_unsigned_i;
  logic [ADDRW+1:0] req_addr_i;
  logic [31:0]      req_wdata_i;
  logic             resp_valid_o;
  logic [31:0]      resp_rdata_o;
  logic             resp_split_o;
  logic             mem_cs_o;
  logic             mem_we_o;
  logic [3:0]       mem_mask_o;
  logic [ADDRW-1:0] mem_addr_o;
  logic [31:0]      mem_wdata_o;
  logic [31:0]      mem_rdata_i;

  lsu_mem_ctrl #(.DW(32), .ADDRW(ADDRW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
    .resp_split_o(resp_split_o),
    .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_mask_o(mem_mask_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Word memory seen by the DUT, and the bench's own byte-level picture of it.
  logic [31:0] tbMem [256] = '{default: 32'h0};
  logic [7:0]  refMem [1024];

  assign mem_rdata_i = tbMem[mem_addr_o];

  always @(posedge clk_i) begin : memWrite
    logic [31:0] w;
    if (mem_cs_o && mem_we_o) begin
      w = tbMem[mem_addr_o];
      for (int l = 0; l < 4; l++)
        if (mem_mask_o[l]) w[8*l +: 8] = mem_wdata_o[8*l +: 8];
      tbMem[mem_addr_o] <= w;
    end
  end

  int testsRun = 0;
  int testsFailed = 0;

  logic [7:0]  beatAddr [$];
  logic [3:0]  beatMask [$];
  logic [31:0] beatData [$];
  logic        beatWe   [$];
  logic [31:0] lastRdata;
  logic        lastSplit;
  int          lastLatency;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Issue one request from a negedge and follow it to its response; returns on
  // the negedge of the response cycle. With hold set, req_valid_i stays high.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [9:0] addr, input logic [31:0] wdata,
                               input logic hold);
    int n, nbeats, cycles, k;
    logic [7:0]  w0, wb;
    logic [9:0]  b;
    logic [1:0]  lane;
    logic [3:0]  expMask [2];
    logic [31:0] expData [2];
    logic [7:0]  expWord [2];
    logic [31:0] loadVal, expRdata;
    bit accepted, gotResp;

    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    req_valid_i = 1'b1; req_we_i = we; req_size_i = size;
    req_unsigned_i = uns; req_addr_i = addr; req_wdata_i = wdata;
    beatAddr.delete(); beatMask.delete(); beatData.delete(); beatWe.delete();

    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready_o) begin accepted = 1; break; end
      @(posedge clk_i); @(negedge clk_i);
      checkOutput("resp_single_pulse", 32'(resp_valid_o), 32'd0);
    end
    if (!accepted) begin
      checkOutput("accept_timeout", 32'(req_ready_o), 32'd1);
      req_valid_i = 1'b0;
      return;
    end
    @(posedge clk_i);

    cycles = 1; gotResp = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      if (!hold) req_valid_i = 1'b0;
      if (resp_valid_o) begin gotResp = 1; break; end
      checkOutput("ready_busy", 32'(req_ready_o), 32'd0);
      checkOutput("split_no_resp", 32'(resp_split_o), 32'd0);
      if (mem_cs_o) begin
        beatAddr.push_back(mem_addr_o); beatMask.push_back(mem_mask_o);
        beatData.push_back(mem_wdata_o); beatWe.push_back(mem_we_o);
      end
      @(posedge clk_i);
      cycles++;
    end
    if (!gotResp) begin
      checkOutput("resp_timeout", 32'(resp_valid_o), 32'd1);
      req_valid_i = 1'b0;
      return;
    end
    lastRdata = resp_rdata_o; lastSplit = resp_split_o; lastLatency = cycles;
    checkOutput("ready_in_resp", 32'(req_ready_o), 32'd0);
    checkOutput("cs_in_resp", 32'(mem_cs_o), 32'd0);

    // Byte-by-byte model: each byte goes to the beat owning its word.
    w0 = addr[9:2]; nbeats = 1; loadVal = 32'h0;
    for (int j = 0; j < 2; j++) begin expMask[j] = 4'h0; expData[j] = 32'h0; expWord[j] = 8'h0; end
    for (int i = 0; i < n; i++) begin
      b = addr + 10'(i); wb = b[9:2]; lane = b[1:0];
      k = (wb == w0) ? 0 : 1;
      if (k == 1) nbeats = 2;
      expWord[k] = wb;
      expMask[k][lane] = 1'b1;
      expData[k][8*lane +: 8] = wdata[8*i +: 8];
      loadVal[8*i +: 8] = refMem[b];
      if (we) refMem[b] = wdata[8*i +: 8];
    end
    if (we) expRdata = 32'h0;
    else if (n == 1) expRdata = uns ? {24'h0, loadVal[7:0]} : {{24{loadVal[7]}}, loadVal[7:0]};
    else if (n == 2) expRdata = uns ? {16'h0, loadVal[15:0]} : {{16{loadVal[15]}}, loadVal[15:0]};
    else expRdata = loadVal;

    checkOutput("latency", 32'(cycles), 32'(nbeats + 1));
    checkOutput("resp_split", 32'(resp_split_o), 32'(nbeats == 2));
    checkOutput("resp_rdata", resp_rdata_o, expRdata);
    checkOutput("beat_count", 32'(beatAddr.size()), 32'(nbeats));
    for (int j = 0; j < nbeats && j < beatAddr.size(); j++) begin
      checkOutput("beat_addr", 32'(beatAddr[j]), 32'(expWord[j]));
      checkOutput("beat_mask", 32'(beatMask[j]), 32'(expMask[j]));
      checkOutput("beat_we", 32'(beatWe[j]), 32'(we));
      if (we) checkOutput("beat_wdata", beatData[j], expData[j]);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) refMem[i] = 8'h0;
    rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00;
    req_unsigned_i = 1'b0; req_addr_i = '0; req_wdata_i = 32'h0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("rst_ready", 32'(req_ready_o), 32'd1);
    checkOutput("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata_o, 32'd0);
    checkOutput("rst_resp_split", 32'(resp_split_o), 32'd0);
    checkOutput("rst_cs", 32'(mem_cs_o), 32'd0);
    checkOutput("rst_we", 32'(mem_we_o), 32'd0);
    checkOutput("rst_mask", 32'(mem_mask_o), 32'd0);
    checkOutput("rst_addr", 32'(mem_addr_o), 32'd0);
    checkOutput("rst_wdata", mem_wdata_o, 32'd0);
    rst_i = 1'b0;

    applyStimulus(1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF, 1'b0);
    checkOutput("sw_addr", 32'(beatAddr[0]), 32'd4);
    checkOutput("sw_mask", 32'(beatMask[0]), 32'hF);
    checkOutput("sw_wdata", beatData[0], 32'hDEADBEEF);
    checkOutput("sw_split", 32'(lastSplit), 32'd0);
    applyStimulus(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 1'b0);
    checkOutput("lw_rdata", lastRdata, 32'hDEADBEEF);
    checkOutput("lw_latency", 32'(lastLatency), 32'd2);

    applyStimulus(1'b1, 2'b00, 1'b0, 10'h013, 32'h00000080, 1'b0);
    checkOutput("sb_mask", 32'(beatMask[0]), 32'h8);
    checkOutput("sb_wdata", beatData[0], 32'h80000000);
    applyStimulus(1'b0, 2'b00, 1'b0, 10'h013, 32'h0, 1'b0);
    checkOutput("lb_signed", lastRdata, 32'hFFFFFF80);
    applyStimulus(1'b0, 2'b00, 1'b1, 10'h013, 32'h0, 1'b0);
    checkOutput("lbu_unsigned", lastRdata, 32'h00000080);

    applyStimulus(1'b1, 2'b01, 1'b0, 10'h023, 32'h0000A55A, 1'b0);
    checkOutput("sh_b0_addr", 32'(beatAddr[0]), 32'd8);
    checkOutput("sh_b0_mask", 32'(beatMask[0]), 32'h8);
    checkOutput("sh_b0_wdata", beatData[0], 32'h5A000000);
    checkOutput("sh_b1_addr", 32'(beatAddr[1]), 32'd9);
    checkOutput("sh_b1_mask", 32'(beatMask[1]), 32'h1);
    checkOutput("sh_b1_wdata", beatData[1], 32'h000000A5);
    applyStimulus(1'b0, 2'b01, 1'b0, 10'h023, 32'h0, 1'b0);
    checkOutput("lh_split_rdata", lastRdata, 32'hFFFFA55A);
    checkOutput("lh_split_flag", 32'(lastSplit), 32'd1);
    checkOutput("lh_split_latency", 32'(lastLatency), 32'd3);

    applyStimulus(1'b1, 2'b10, 1'b0, 10'h3FE, 32'h11223344, 1'b0);
    checkOutput("wrap_b0_addr", 32'(beatAddr[0]), 32'd255);
    checkOutput("wrap_b0_mask", 32'(beatMask[0]), 32'hC);
    checkOutput("wrap_b1_addr", 32'(beatAddr[1]), 32'd0);
    checkOutput("wrap_b1_mask", 32'(beatMask[1]), 32'h3);
    checkOutput("wrap_mem255", tbMem[255], 32'h33440000);
    checkOutput("wrap_mem0", tbMem[0], 32'h00001122);
    applyStimulus(1'b0, 2'b10, 1'b0, 10'h3FC, 32'h0, 1'b0);
    checkOutput("wrap_load255", lastRdata, 32'h33440000);
    applyStimulus(1'b0, 2'b10, 1'b0, 10'h000, 32'h0, 1'b0);
    checkOutput("wrap_load0", lastRdata, 32'h00001122);

    // Back-to-back with valid held high between requests.
    applyStimulus(1'b1, 2'b10, 1'b0, 10'h040, 32'hCAFEF00D, 1'b1);
    applyStimulus(1'b1, 2'b01, 1'b0, 10'h047, 32'h00007E81, 1'b1);
    applyStimulus(1'b0, 2'b10, 1'b0, 10'h040, 32'h0, 1'b1);
    applyStimulus(1'b0, 2'b01, 1'b1, 10'h047, 32'h0, 1'b0);
    checkOutput("b2b_last_rdata", lastRdata, 32'h00007E81);

    // Reset during beat 0 of a split store: beat 1 must never appear.
    begin : resetMidAccess
      bit rdy;
      rdy = 0;
      for (int i = 0; i < 10 && !rdy; i++) begin
        @(negedge clk_i);
        rdy = req_ready_o;
      end
      req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'b01; req_unsigned_i = 1'b0;
      req_addr_i = 10'h0A7; req_wdata_i = 32'h00001234;
      @(posedge clk_i); @(negedge clk_i);
      req_valid_i = 1'b0;
      checkOutput("rstmid_beat0_cs", 32'(mem_cs_o), 32'd1);
      checkOutput("rstmid_beat0_addr", 32'(mem_addr_o), 32'd41);
      rst_i = 1'b1;
      @(posedge clk_i); @(negedge clk_i);
      rst_i = 1'b0;
      checkOutput("rstmid_cs", 32'(mem_cs_o), 32'd0);
      checkOutput("rstmid_ready", 32'(req_ready_o), 32'd1);
      checkOutput("rstmid_resp", 32'(resp_valid_o), 32'd0);
      refMem[10'h0A7] = 8'h34;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk_i); @(negedge clk_i);
        checkOutput("rstmid_no_resp", 32'(resp_valid_o), 32'd0);
        checkOutput("rstmid_no_beat", 32'(mem_cs_o), 32'd0);
      end
      applyStimulus(1'b0, 2'b01, 1'b1, 10'h0A7, 32'h0, 1'b0);
      checkOutput("rstmid_partial", lastRdata, 32'h00000034);
    end

    for (int t = 0; t < 300; t++) begin
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
                    $urandom, 1'($urandom_range(0, 1)));
    end
    req_valid_i = 1'b0;

    for (int w = 0; w < 256; w++) begin
      if (tbMem[w] !== {refMem[4*w+3], refMem[4*w+2], refMem[4*w+1], refMem[4*w]})
        checkOutput("final_mem", tbMem[w],
                    {refMem[4*w+3], refMem[4*w+2], refMem[4*w+1], refMem[4*w]});
    end
    checkOutput("final_mem_word0", tbMem[0], {refMem[3], refMem[2], refMem[1], refMem[0]});

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store initiator between the execute stage and the word-addressed, byte-masked data memory. It accepts byte-addressed load/store requests of byte, half or word size, and generates word address, chip-select, write-enable, byte mask and lane-shifted write data. It assembles and sign- or zero-extends load data. Accesses that cross a word boundary are split into two memory beats, so the pipeline sees one request and one response.

Parameters:
DW, 32, data width; fixed at 32 (4 byte lanes).
ADDRW, 8, memory word-address width; the request byte address is ADDRW+2 bits.

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
req_valid_i  input  1  request valid
req_ready_o  output  1  request accepted when valid & ready
req_we_i  input  1  1 = store, 0 = load
req_size_i  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
req_unsigned_i  input  1  load zero-extend when 1, sign-extend when 0
req_addr_i  input  ADDRW+2  byte address
req_wdata_i  input  32  store data, right-aligned
resp_valid_o  output  1  one-cycle completion pulse (loads and stores)
resp_rdata_o  output  32  extended load data; 0 for stores
resp_split_o  output  1  valid with resp: access used two beats
mem_cs_o  output  1  memory chip-select
mem_we_o  output  1  memory write-enable
mem_mask_o  output  4  byte-lane enables
mem_addr_o  output  ADDRW  word address
mem_wdata_o  output  32  lane-aligned write data
mem_rdata_i  input  32  memory read data (combinational, same cycle as mem_addr_o)

Behaviour:
- Reset: clocked on posedge clk_i; rst_i is sampled synchronously.
  - Forces state IDLE and clears all request/capture registers.
  - Output values under reset: req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_split_o=0, mem_cs_o=0, mem_we_o=0, mem_mask_o=0, mem_addr_o=0, mem_wdata_o=0.
  - Reset mid-operation abandons the access. No further beat is issued; a partially completed split store is not rolled back.
- States: IDLE, BEAT0, BEAT1, RESP.
  - IDLE: req_ready_o=1. When req_valid_i is high, register the request and go to BEAT0.
  - BEAT0: drive beat 0, capture mem_rdata_i. Go to BEAT1 if the access crosses a word boundary, else to RESP.
  - BEAT1: drive beat 1, capture mem_rdata_i, go to RESP.
  - RESP: resp_valid_o=1 for exactly one cycle, then go to IDLE.
- req_ready_o=1 only in IDLE, so a new request is never accepted in RESP.
- Memory outputs are valid only in BEAT0/BEAT1, and all are 0 in other states.
  - mem_cs_o=1 in both beats.
  - mem_we_o = the registered we value in both beats.
- Lane math:
  - off = addr[1:0]; nbytes = 1/2/4 from size.
  - en8 = ((1<<nbytes)-1) << off, 8 bits wide.
  - Split when en8[7:4] != 0.
  - Beat 0: mem_addr_o = addr[ADDRW+1:2], mem_mask_o = en8[3:0], mem_wdata_o = low 32 bits of (wdata masked to nbytes) << 8*off.
  - Beat 1: mem_addr_o = word address + 1, modulo 2^ADDRW (wraps from the top word to word 0); mem_mask_o = en8[7:4]; mem_wdata_o = high 32 bits of the shifted data.
  - Unmasked lanes of mem_wdata_o are 0.
- Load assembly:
  - raw = ({beat1_capture, beat0_capture} >> 8*off)[31:0], where beat1_capture = 0 if there was no split.
  - Keep the low nbytes; extend from bit 8*nbytes-1 by sign or zero according to req_unsigned_i.
  - Word loads ignore req_unsigned_i.
- Latency, with acceptance at edge k:
  - Aligned access: resp_valid_o high in the cycle after edge k+1 (2 cycles).
  - Split access: resp_valid_o high in the cycle after edge k+2 (3 cycles).
- Stores: resp_rdata_o=0 and resp_valid_o pulses as an acknowledge.
- resp_split_o is valid only while resp_valid_o=1, and 0 otherwise.

Test Plan:
- Store word 0xDEADBEEF to byte addr 0x010, then load word at 0x010.
  - Store beat: mem_addr_o=4, mem_mask_o=1111, mem_wdata_o=0xDEADBEEF, no split.
  - Load response: resp_rdata_o=0xDEADBEEF, 2-cycle latency.
- Store byte 0x80 to 0x013, then load byte at 0x013.
  - Store beat: mem_mask_o=1000, mem_wdata_o=0x80000000.
  - Signed load returns 0xFFFFFF80; unsigned load returns 0x00000080.
- Store half 0xA55A to 0x023 (split), then load half at 0x023.
  - Beat 0: addr 8, mask 1000, wdata 0x5A000000.
  - Beat 1: addr 9, mask 0001, wdata 0x000000A5.
  - Load returns 0xFFFFA55A with resp_split_o=1 and 3-cycle latency.
- Word store 0x11223344 at byte addr 0x3FE (ADDRW=8).
  - Beat 0: addr 255, mask 1100.
  - Beat 1: addr 0, mask 0011, showing the wrap-around.
  - Word 255 reads 0x33440000 and word 0 reads 0x00001122.
- Back-to-back requests with req_valid_i held high.
  - req_ready_o is low in BEAT0/BEAT1/RESP.
  - The second request is accepted on the first IDLE cycle; no request is lost or duplicated.
- Assert rst_i during BEAT0 of a split store.
  - Next cycle: IDLE, mem_cs_o=0, no BEAT1 issued, resp_valid_o never pulses, req_ready_o=1.
